// File: rtl/miriscv_lsu_if.sv
// Core-side request/response and data-memory port bundle for the load/store unit.
// The LSU uses the slave modport; the driver of requests and the memory model use master.
interface miriscv_lsu_if;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_o;
  logic        lsu_fault_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic        mem_we_o;
  logic [31:0] mem_rd_i;

  modport slave (
    input  lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i, mem_rd_i,
    output lsu_data_o, lsu_stall_o, lsu_fault_o, mem_addr_o, mem_wd_o, mem_we_o
  );

  modport master (
    output lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i, mem_rd_i,
    input  lsu_data_o, lsu_stall_o, lsu_fault_o, mem_addr_o, mem_wd_o, mem_we_o
  );
endinterface

// File: rtl/miriscv_lsu.sv
// RV32I load/store unit: loads, SW and faults take 2 cycles, SB/SH 3 (read-modify-write).
// The core is held via lsu_stall_o until the RESP cycle; accepted operations always complete.
module miriscv_lsu #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic          clk_i,
  input  logic          rst_i,
  miriscv_lsu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, data_q;
  logic        fault_q;

  logic        err, is_half, is_word, bad_size, misal, oor;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext, st_word;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic        mem_we;

  always_comb begin
    bad_size = (bus.lsu_size_i == 3'b011) || (bus.lsu_size_i[2:1] == 2'b11);
    is_half  = (bus.lsu_size_i[1:0] == 2'b01);
    is_word  = (bus.lsu_size_i[1:0] == 2'b10);
    misal    = (is_half && bus.lsu_addr_i[0]) || (is_word && (bus.lsu_addr_i[1:0] != 2'b00));
    oor      = (bus.lsu_addr_i >= MEM_BYTES);
    err      = bad_size || misal || oor || (bus.lsu_we_i && bus.lsu_size_i[2]);
  end

  // Load extraction straight from the combinational memory read in the accept cycle.
  always_comb begin
    case (bus.lsu_addr_i[1:0])
      2'd0:    ld_byte = bus.mem_rd_i[7:0];
      2'd1:    ld_byte = bus.mem_rd_i[15:8];
      2'd2:    ld_byte = bus.mem_rd_i[23:16];
      default: ld_byte = bus.mem_rd_i[31:24];
    endcase
    ld_half = bus.lsu_addr_i[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
    case (bus.lsu_size_i)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      3'b010:  ld_ext = bus.mem_rd_i;
      default: ld_ext = 32'd0;
    endcase
  end

  always_comb begin
    st_word = bus.mem_rd_i;
    case (bus.lsu_size_i[1:0])
      2'b00:   st_word[{bus.lsu_addr_i[1:0], 3'b000} +: 8]  = bus.lsu_data_i[7:0];
      2'b01:   st_word[{bus.lsu_addr_i[1], 4'b0000} +: 16] = bus.lsu_data_i[15:0];
      default: st_word = bus.lsu_data_i;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    mem_we         = 1'b0;
    bus.mem_wd_o   = bus.lsu_data_i;
    bus.mem_addr_o = bus.lsu_addr_i;
    resp_data      = 32'd0;
    resp_fault     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.lsu_req_i) begin
          resp_fault = err;
          resp_data  = (err || bus.lsu_we_i) ? 32'd0 : ld_ext;
          if (err || !bus.lsu_we_i) begin
            state_d = RESP;
          end else if (is_word) begin
            mem_we  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WR;
          end
        end
      end
      WR: begin
        bus.mem_addr_o = addr_q;
        bus.mem_wd_o   = wdata_q;
        mem_we         = 1'b1;
        state_d        = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset must also cancel a write already presented in this cycle.
  assign bus.mem_we_o    = mem_we & ~rst_i;
  assign bus.lsu_stall_o = (state_q == WR) || (bus.lsu_req_i && (state_q != RESP));
  assign bus.lsu_data_o  = data_q;
  assign bus.lsu_fault_o = fault_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.lsu_req_i) begin
        addr_q  <= bus.lsu_addr_i;
        wdata_q <= st_word;
      end
      // Response registers change only on entry to RESP; fault is a one-cycle flag.
      if (state_d == RESP) begin
        data_q  <= resp_data;
        fault_q <= resp_fault;
      end else if (state_q == RESP) begin
        fault_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu with a 64-word memory model and hand-computed expectations.
module tb_miriscv_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  miriscv_lsu_if bus ();

  miriscv_lsu #(.MEM_BYTES(256)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  logic [31:0] mem [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_dat = 32'd0;
  int          we_cnt = 0;

  assign bus.mem_rd_i = mem[bus.mem_addr_o[7:2]];

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_idx] <= pre_dat;
    else if (bus.mem_we_o)
      mem[bus.mem_addr_o[7:2]] <= bus.mem_wd_o;
    if (bus.mem_we_o)
      we_cnt <= we_cnt + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] dat);
    pre_idx = idx;
    pre_dat = dat;
    pre_we  = 1'b1;
    @(negedge clk); #1;
    pre_we  = 1'b0;
  endtask

  // Called mid-cycle; returns one cycle after the RESP cycle.
  task automatic run_op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdat, input bit keep,
                        output logic [31:0] rdat, output logic flt,
                        output int stalls, output int wes);
    int w0;
    bit to;
    w0 = we_cnt;
    stalls = 0;
    to = 1'b0;
    bus.lsu_req_i  = 1'b1;
    bus.lsu_we_i   = we;
    bus.lsu_size_i = size;
    bus.lsu_addr_i = addr;
    bus.lsu_data_i = wdat;
    #1;
    while (bus.lsu_stall_o && !to) begin
      stalls++;
      if (stalls > 8) to = 1'b1;
      else begin @(negedge clk); #1; end
    end
    if (to) check("op_timeout", {31'd0, to}, 32'd0);
    rdat = bus.lsu_data_o;
    flt  = bus.lsu_fault_o;
    if (!keep) bus.lsu_req_i = 1'b0;
    @(negedge clk); #1;
    wes = we_cnt - w0;
  endtask

  logic [31:0] rd;
  logic        fl;
  int          st, wc, w0;

  initial begin
    bus.lsu_req_i  = 1'b0;
    bus.lsu_we_i   = 1'b0;
    bus.lsu_size_i = 3'b010;
    bus.lsu_addr_i = 32'd0;
    bus.lsu_data_i = 32'd0;
    @(negedge clk); @(negedge clk); #1;
    check("rst_data",  bus.lsu_data_o, 32'd0);
    check("rst_fault", {31'd0, bus.lsu_fault_o}, 32'd0);
    check("rst_we",    {31'd0, bus.mem_we_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Word path
    run_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, rd, fl, st, wc);
    check("sw_stall", st, 1);
    check("sw_wes",   wc, 1);
    check("sw_mem",   mem[4], 32'hDEADBEEF);
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, fl, st, wc);
    check("lw_stall", st, 1);
    check("lw_data",  rd, 32'hDEADBEEF);
    check("lw_fault", {31'd0, fl}, 32'd0);

    // Sub-word loads
    poke(6'd8, 32'h80FF7F01);
    run_op(1'b0, 3'b000, 32'h23, 32'h0, 1'b0, rd, fl, st, wc);
    check("lb_23",  rd, 32'hFFFFFF80);
    run_op(1'b0, 3'b100, 32'h23, 32'h0, 1'b0, rd, fl, st, wc);
    check("lbu_23", rd, 32'h00000080);
    run_op(1'b0, 3'b001, 32'h22, 32'h0, 1'b0, rd, fl, st, wc);
    check("lh_22",  rd, 32'hFFFF80FF);
    run_op(1'b0, 3'b101, 32'h20, 32'h0, 1'b0, rd, fl, st, wc);
    check("lhu_20", rd, 32'h00007F01);
    run_op(1'b0, 3'b000, 32'h21, 32'h0, 1'b0, rd, fl, st, wc);
    check("lb_21",  rd, 32'h0000007F);

    // Read-modify-write stores
    poke(6'd12, 32'h11223344);
    run_op(1'b1, 3'b000, 32'h31, 32'h123456AB, 1'b0, rd, fl, st, wc);
    check("sb_stall", st, 2);
    check("sb_wes",   wc, 1);
    check("sb_mem",   mem[12], 32'h1122AB44);
    check("sb_data",  rd, 32'd0);
    run_op(1'b1, 3'b001, 32'h32, 32'h9876CDEF, 1'b0, rd, fl, st, wc);
    check("sh_stall", st, 2);
    check("sh_mem",   mem[12], 32'hCDEFAB44);

    // Faults
    run_op(1'b0, 3'b010, 32'h30, 32'h0, 1'b0, rd, fl, st, wc);
    check("lw_30", rd, 32'hCDEFAB44);
    run_op(1'b0, 3'b010, 32'h12, 32'h0, 1'b0, rd, fl, st, wc);
    check("f_lw12_fault", {31'd0, fl}, 32'd1);
    check("f_lw12_data",  rd, 32'd0);
    check("f_lw12_stall", st, 1);
    check("f_clear",      {31'd0, bus.lsu_fault_o}, 32'd0);
    run_op(1'b1, 3'b001, 32'h31, 32'hFFFF, 1'b0, rd, fl, st, wc);
    check("f_sh31_fault", {31'd0, fl}, 32'd1);
    check("f_sh31_wes",   wc, 0);
    run_op(1'b1, 3'b100, 32'h30, 32'hFF, 1'b0, rd, fl, st, wc);
    check("f_s100_fault", {31'd0, fl}, 32'd1);
    check("f_s100_wes",   wc, 0);
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 1'b0, rd, fl, st, wc);
    check("f_oor_fault",  {31'd0, fl}, 32'd1);
    check("f_oor_data",   rd, 32'd0);
    run_op(1'b0, 3'b011, 32'h30, 32'h0, 1'b0, rd, fl, st, wc);
    check("f_size011",    {31'd0, fl}, 32'd1);
    check("f_mem_kept",   mem[12], 32'hCDEFAB44);

    // Reset while a sub-word store sits in WR
    poke(6'd16, 32'hA5A5A5A5);
    run_op(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, rd, fl, st, wc);
    check("lw_40", rd, 32'hA5A5A5A5);
    bus.lsu_req_i  = 1'b1;
    bus.lsu_we_i   = 1'b1;
    bus.lsu_size_i = 3'b000;
    bus.lsu_addr_i = 32'h41;
    bus.lsu_data_i = 32'h11;
    @(negedge clk); #1;
    check("wr_stall", {31'd0, bus.lsu_stall_o}, 32'd1);
    w0  = we_cnt;
    rst = 1'b1;
    #1;
    check("wr_rst_we", {31'd0, bus.mem_we_o}, 32'd0);
    @(negedge clk); #1;
    bus.lsu_req_i = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    check("rst2_wes",   we_cnt - w0, 0);
    check("rst2_mem",   mem[16], 32'hA5A5A5A5);
    check("rst2_data",  bus.lsu_data_o, 32'd0);
    check("rst2_fault", {31'd0, bus.lsu_fault_o}, 32'd0);
    @(negedge clk); #1;
    run_op(1'b0, 3'b010, 32'h40, 32'h0, 1'b0, rd, fl, st, wc);
    check("rst2_idle_stall", st, 1);
    check("rst2_lw",         rd, 32'hA5A5A5A5);

    // Request dropped while in WR
    w0 = we_cnt;
    bus.lsu_req_i  = 1'b1;
    bus.lsu_we_i   = 1'b1;
    bus.lsu_size_i = 3'b000;
    bus.lsu_addr_i = 32'h42;
    bus.lsu_data_i = 32'h5A;
    @(negedge clk); #1;
    bus.lsu_req_i = 1'b0;
    #1;
    check("drop_wr_stall", {31'd0, bus.lsu_stall_o}, 32'd1);
    @(negedge clk); @(negedge clk); #1;
    check("drop_wes", we_cnt - w0, 1);
    check("drop_mem", mem[16], 32'hA55AA5A5);

    // Back-to-back LW / SB / LW with request held high
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, rd, fl, st, wc);
    check("b2b_lw1_stall", st, 1);
    check("b2b_lw1_data",  rd, 32'hDEADBEEF);
    run_op(1'b1, 3'b000, 32'h10, 32'h77, 1'b1, rd, fl, st, wc);
    check("b2b_sb_stall",  st, 2);
    check("b2b_sb_wes",    wc, 1);
    run_op(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, fl, st, wc);
    check("b2b_lw2_stall", st, 1);
    check("b2b_lw2_data",  rd, 32'hDEADBE77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
